pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central sequencer for the 5-stage pipeline's freeze/flush/bubble controls.
//  Combines hazard_Detected (ID), taken branch (ID) and multi-cycle SRAM
//  accesses (MEM) into one consistent set of stage-register controls.
//  Owns the memory-wait state and counts stall cycles and memory timeouts.
//  Sits beside the ID stage; drives the PC, IF/ID, ID/EXE and back-end
//  (EXE/MEM, MEM/WB) pipeline registers.
// PARAMETERS
//  FLUSH_SLOTS  1   IF/ID flush cycles after a taken branch (1..3)
//  MEM_TIMEOUT  64  MEM_WAIT cycles before mem_timeout is set (>=2)
//  CNT_W        16  stall_count width
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      synchronous, active-high reset
//  hazard_detected  in   1      RAW hazard from hazard detection unit (comb.)
//  branch_taken     in   1      ID-stage branch resolved taken
//  mem_req          in   1      MEM stage holds a load/store this cycle
//  sram_ready       in   1      SRAM controller: access completes this cycle
//  freeze_pc        out  1      hold PC
//  freeze_if_id     out  1      hold IF/ID register
//  bubble_id_exe    out  1      load NOP (all control bits 0) into ID/EXE
//  flush_if_id      out  1      clear IF/ID register
//  freeze_back      out  1      hold ID/EXE, EXE/MEM, MEM/WB registers
//  state_o          out  2      FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH
//  stall_count      out  CNT_W  saturating count of freeze_pc cycles
//  mem_timeout      out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  - Reset (sync): state=RUN, flush_cnt=0, wait_cnt=0, stall_count=0,
//    mem_timeout=0. While rst=1, all control outputs are forced 0.
//  - Control outputs are Mealy: functions of the registered state and the
//    current inputs. They take effect at the same clock edge.
//  - Priority in RUN: memory > hazard > branch.
//  - RUN, mem_req & !sram_ready:
//    freeze_pc=freeze_if_id=freeze_back=1, bubble_id_exe=0.
//    Next state MEM_WAIT; wait_cnt<=1.
//  - RUN, else hazard_detected:
//    freeze_pc=freeze_if_id=bubble_id_exe=1. Stay in RUN.
//    branch_taken is ignored this cycle (operands are stale); it is
//    re-evaluated next cycle.
//  - RUN, else branch_taken: flush_if_id=1, no freeze.
//    If FLUSH_SLOTS>1: next state FLUSH, flush_cnt<=FLUSH_SLOTS-1.
//  - RUN, else: all controls 0.
//  - MEM_WAIT, !sram_ready:
//    freeze_pc=freeze_if_id=freeze_back=1; hazard and branch are ignored.
//    wait_cnt increments, saturating. When wait_cnt==MEM_TIMEOUT,
//    mem_timeout<=1. The FSM keeps waiting; there is no abort.
//  - MEM_WAIT, sram_ready: all freezes 0 in this cycle (the pipeline
//    advances). Next state RUN; wait_cnt<=0.
//  - FLUSH: flush_if_id=1; flush_cnt decrements; at 1 -> RUN.
//    A mem_req & !sram_ready in FLUSH: behave as RUN-memory entry
//    (freeze all, flush_if_id stays 1); flush_cnt is dropped.
//  - stall_count: +1 on every cycle with freeze_pc=1; holds at 2^CNT_W-1.
//  - mem_req & sram_ready in the same RUN cycle (single-cycle hit):
//    no freeze, no state change.
//  - Reset mid-MEM_WAIT: returns to RUN immediately. The SRAM controller
//    is reset by the same rst.
// STRUCTURE
//  - Shared header pipeline_defs.vh:
//    - state encodings ST_RUN/ST_MEM_WAIT/ST_FLUSH
//    - NOP control-word constant
//  - One sub-module: sat_counter #(W) (en, clr, q), used for stall_count
//    and wait_cnt.
//  - FSM plus output decode in the top module; no other hierarchy.
// TESTING
//  1. rst=1 for 2 cycles with all inputs=1
//     -> all outputs 0, state_o=0, stall_count=0.
//  2. hazard_detected=1 for 2 cycles
//     -> freeze_pc=freeze_if_id=bubble_id_exe=1 both cycles; stall_count=2.
//  3. mem_req=1, sram_ready low for 4 cycles then high
//     -> freeze_back=1 for 4 cycles, 0 on the ready cycle; state 0,1,1,1,1,0.
//  4. hazard_detected=1 & branch_taken=1 together -> bubble=1, flush_if_id=0.
//     Next cycle branch_taken only -> flush_if_id=1.
//  5. FLUSH_SLOTS=3, branch_taken pulse -> flush_if_id=1 for 3 cycles,
//     state 0,2,2,0.
//  6. MEM_TIMEOUT=8, sram_ready never -> mem_timeout=1 after 8 wait cycles
//     and stays 1. Freezes held until rst; stall_count saturates with CNT_W=4.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding and
// the stage-control word with its all-zero NOP value.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic bubble_id_exe;
        logic flush_if_id;
        logic freeze_back;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = 5'b00000;

    // Memory stall freezes the whole pipeline; an in-progress IF/ID flush is kept.
    function automatic ctrl_t ctrl_mem_stall(input logic flush);
        ctrl_t c;
        c               = CTRL_NOP;
        c.freeze_pc     = 1'b1;
        c.freeze_if_id  = 1'b1;
        c.freeze_back   = 1'b1;
        c.flush_if_id   = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter that sticks at all-ones; used for stall and memory-wait counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Counter register: clear dominates, increment stops at the maximum.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= {W{1'b0}};
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush/bubble sequencer for the 5-stage pipeline. Controls are
// Mealy outputs of the registered state and the current hazard/branch/memory inputs.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int FLUSH_SLOTS = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_back,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_SLOTS - 1);

    state_e            state_r, next_state_s;
    logic [1:0]        flush_cnt_r, flush_cnt_next_s;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              wait_en_s, wait_clr_s, timeout_set_s, mem_stall_s;
    ctrl_t             ctrl_s, ctrl_out_s;

    // Next-state and control decode; priority in RUN is memory > hazard > branch.
    always_comb begin
        ctrl_s           = CTRL_NOP;
        next_state_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        wait_en_s        = 1'b0;
        wait_clr_s       = 1'b0;
        timeout_set_s    = 1'b0;
        mem_stall_s      = mem_req && !sram_ready;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    ctrl_s       = ctrl_mem_stall(1'b0);
                    next_state_s = ST_MEM_WAIT;
                    wait_en_s    = 1'b1;
                end else if (hazard_detected) begin
                    ctrl_s.freeze_pc     = 1'b1;
                    ctrl_s.freeze_if_id  = 1'b1;
                    ctrl_s.bubble_id_exe = 1'b1;
                end else if (branch_taken) begin
                    ctrl_s.flush_if_id = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        next_state_s     = ST_FLUSH;
                        flush_cnt_next_s = FLUSH_INIT;
                    end else begin
                        next_state_s     = ST_RUN;
                    end
                end else begin
                    ctrl_s = CTRL_NOP;
                end
            end
            ST_MEM_WAIT: begin
                if (!sram_ready) begin
                    ctrl_s        = ctrl_mem_stall(1'b0);
                    wait_en_s     = 1'b1;
                    timeout_set_s = (wait_cnt_s >= TIMEOUT_V);
                end else begin
                    next_state_s = ST_RUN;
                    wait_clr_s   = 1'b1;
                end
            end
            ST_FLUSH: begin
                ctrl_s.flush_if_id = 1'b1;
                if (mem_stall_s) begin
                    ctrl_s           = ctrl_mem_stall(1'b1);
                    next_state_s     = ST_MEM_WAIT;
                    flush_cnt_next_s = 2'd0;
                    wait_en_s        = 1'b1;
                end else if (flush_cnt_r <= 2'd1) begin
                    next_state_s     = ST_RUN;
                    flush_cnt_next_s = 2'd0;
                end else begin
                    flush_cnt_next_s = flush_cnt_r - 2'd1;
                end
            end
            default: begin
                next_state_s     = ST_RUN;
                flush_cnt_next_s = 2'd0;
            end
        endcase
    end

    // State, flush slot counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 2'd0;
            mem_timeout <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            flush_cnt_r <= flush_cnt_next_s;
            mem_timeout <= mem_timeout | timeout_set_s;
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr_s),
        .en  (wait_en_s),
        .q   (wait_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (ctrl_out_s.freeze_pc),
        .q   (stall_count)
    );

    assign ctrl_out_s    = rst ? CTRL_NOP : ctrl_s;
    assign freeze_pc     = ctrl_out_s.freeze_pc;
    assign freeze_if_id  = ctrl_out_s.freeze_if_id;
    assign bubble_id_exe = ctrl_out_s.bubble_id_exe;
    assign flush_if_id   = ctrl_out_s.flush_if_id;
    assign freeze_back   = ctrl_out_s.freeze_back;
    assign state_o       = state_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: the driver pushes expected per-cycle outputs from a
// behavioural model; a negedge monitor pops and compares them to the DUT.
module tb_pipeline_stall_controller;

    localparam int FS   = 3;
    localparam int MT   = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hazard_detected = 1'b1, branch_taken = 1'b1;
    logic          mem_req = 1'b1, sram_ready = 1'b1;
    logic          freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_count;
    logic          mem_timeout;

    typedef struct {
        logic [4:0] ctrl;
        int         st;
        int         cnt;
        int         to;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // behavioural model state (0 run, 1 waiting on memory, 2 flushing)
    int m_mode = 0, m_flush_left = 0, m_waited = 0, m_stalls = 0, m_timeout = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.FLUSH_SLOTS(FS), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .sram_ready      (sram_ready),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .bubble_id_exe   (bubble_id_exe),
        .flush_if_id     (flush_if_id),
        .freeze_back     (freeze_back),
        .state_o         (state_o),
        .stall_count     (stall_count),
        .mem_timeout     (mem_timeout)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // One clock cycle of stimulus; the model produces this cycle's expected outputs.
    task automatic drive(input logic r, input logic hz, input logic br,
                         input logic mr, input logic rdy);
        exp_t e;
        logic fpc, fif, bub, fl, fb;
        int   nmode;
        @(posedge clk);
        #1;
        rst = r; hazard_detected = hz; branch_taken = br; mem_req = mr; sram_ready = rdy;
        fpc = 1'b0; fif = 1'b0; bub = 1'b0; fl = 1'b0; fb = 1'b0;
        e.st  = m_mode;
        e.cnt = m_stalls;
        e.to  = m_timeout;
        nmode = m_mode;
        if (r) begin
            nmode = 0; m_flush_left = 0; m_waited = 0; m_stalls = 0; m_timeout = 0;
        end else begin
            if (m_mode == 0) begin
                if (mr && !rdy) begin
                    fpc = 1'b1; fif = 1'b1; fb = 1'b1; nmode = 1; m_waited = 1;
                end else if (hz) begin
                    fpc = 1'b1; fif = 1'b1; bub = 1'b1;
                end else if (br) begin
                    fl = 1'b1;
                    if (FS > 1) begin nmode = 2; m_flush_left = FS - 1; end
                end
            end else if (m_mode == 1) begin
                if (!rdy) begin
                    fpc = 1'b1; fif = 1'b1; fb = 1'b1;
                    if (m_waited >= MT) m_timeout = 1;
                    m_waited++;
                end else begin
                    nmode = 0; m_waited = 0;
                end
            end else begin
                fl = 1'b1;
                if (mr && !rdy) begin
                    fpc = 1'b1; fif = 1'b1; fb = 1'b1;
                    nmode = 1; m_waited = 1; m_flush_left = 0;
                end else begin
                    m_flush_left--;
                    if (m_flush_left == 0) nmode = 0;
                end
            end
            if (fpc && m_stalls < MAXC) m_stalls++;
        end
        e.ctrl = {fpc, fif, bub, fl, fb};
        exp_q.push_back(e);
        m_mode = nmode;
    endtask

    // Monitor: every cycle the DUT presents a full output set mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("freeze_pc",     int'(freeze_pc),     int'(e.ctrl[4]));
                chk("freeze_if_id",  int'(freeze_if_id),  int'(e.ctrl[3]));
                chk("bubble_id_exe", int'(bubble_id_exe), int'(e.ctrl[2]));
                chk("flush_if_id",   int'(flush_if_id),   int'(e.ctrl[1]));
                chk("freeze_back",   int'(freeze_back),   int'(e.ctrl[0]));
                chk("state_o",       int'(state_o),       e.st);
                chk("stall_count",   int'(stall_count),   e.cnt);
                chk("mem_timeout",   int'(mem_timeout),   e.to);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with every input high
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        // back-to-back hazards
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // four-cycle memory wait then ready
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // hazard masks branch, branch taken next cycle, flush slots follow
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // memory stall arriving during a flush
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        // single-cycle hit
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        // memory never ready: timeout, stall_count saturation, reset mid-wait
        repeat (25) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 63) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 4) < 2),
                  logic'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
